// File: rtl/rf_pkg.sv
// Shared defaults and convenience types for the pipelined-core register file.
package rf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0]  rf_addr_t;
    typedef logic [31:0] rf_word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one bit per register plus a registered population count.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS    = NREGS_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [AW-1:0]    rf_ia,
    input  logic             rf_en,
    input  logic [AW-1:0]    rf_wa,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      pend_cnt
);

    logic [NREGS-1:0] pend_nxt;
    logic [AW:0]      cnt_nxt;

    // Writeback clears first so that a same-cycle issue to that register wins.
    always_comb begin
        pend_nxt = pending;
        cnt_nxt  = '0;
        if (flush) begin
            pend_nxt = '0;
        end else begin
            if (rf_en)  pend_nxt[rf_wa] = 1'b0;
            if (iss_en) pend_nxt[rf_ia] = 1'b1;
            if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
        end
        for (int r = 0; r < NREGS; r++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with optional bypass and zero register,
// plus a pending-writeback scoreboard used by decode for stall generation.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rf_adr1,
    input  logic [AW-1:0]   rf_adr2,
    output logic [XLEN-1:0] rf_rs1,
    output logic [XLEN-1:0] rf_rs2,
    input  logic            rf_en,
    input  logic [AW-1:0]   rf_wa,
    input  logic [XLEN-1:0] rf_wd,
    input  logic            iss_en,
    input  logic [AW-1:0]   rf_ia,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     pend_cnt,
    input  logic            flush
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pending;
    logic             wr_ok;
    logic             zero1, zero2;
    logic             hit1, hit2;

    assign wr_ok = rf_en && !((ZERO_REG != 0) && (rf_wa == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[rf_wa] <= rf_wd;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .rf_ia    (rf_ia),
        .rf_en    (rf_en),
        .rf_wa    (rf_wa),
        .flush    (flush),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    // The zero register outranks the bypass path, for both data and busy.
    assign zero1 = (ZERO_REG != 0) && (rf_adr1 == '0);
    assign zero2 = (ZERO_REG != 0) && (rf_adr2 == '0);
    assign hit1  = (BYPASS != 0) && rf_en && (rf_wa == rf_adr1);
    assign hit2  = (BYPASS != 0) && rf_en && (rf_wa == rf_adr2);

    assign rf_rs1 = zero1 ? '0 : (hit1 ? rf_wd : mem[rf_adr1]);
    assign rf_rs2 = zero2 ? '0 : (hit2 ? rf_wd : mem[rf_adr2]);
    assign busy1  = pending[rf_adr1] && !zero1 && !hit1;
    assign busy2  = pending[rf_adr2] && !zero2 && !hit2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: default config against a behavioural
// model, plus a 16x64 no-bypass instance exercised directly.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: XLEN=32, NREGS=32, ZERO_REG=1, BYPASS=1
    logic [4:0]  a_adr1 = '0, a_adr2 = '0, a_wa = '0, a_ia = '0;
    logic        a_en = 1'b0, a_iss = 1'b0, a_flush = 1'b0;
    logic [31:0] a_wd = '0;
    logic [31:0] a_rs1, a_rs2;
    logic        a_busy1, a_busy2;
    logic [5:0]  a_pcnt;

    reg_file_sb u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rf_adr1(a_adr1), .rf_adr2(a_adr2), .rf_rs1(a_rs1), .rf_rs2(a_rs2),
        .rf_en(a_en), .rf_wa(a_wa), .rf_wd(a_wd),
        .iss_en(a_iss), .rf_ia(a_ia),
        .busy1(a_busy1), .busy2(a_busy2), .pend_cnt(a_pcnt), .flush(a_flush)
    );

    // Narrow/wide configuration without bypass
    logic [3:0]  b_adr1 = '0, b_adr2 = '0, b_wa = '0, b_ia = '0;
    logic        b_en = 1'b0, b_iss = 1'b0, b_flush = 1'b0;
    logic [63:0] b_wd = '0;
    logic [63:0] b_rs1, b_rs2;
    logic        b_busy1, b_busy2;
    logic [4:0]  b_pcnt;

    reg_file_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rf_adr1(b_adr1), .rf_adr2(b_adr2), .rf_rs1(b_rs1), .rf_rs2(b_rs2),
        .rf_en(b_en), .rf_wa(b_wa), .rf_wd(b_wd),
        .iss_en(b_iss), .rf_ia(b_ia),
        .busy1(b_busy1), .busy2(b_busy2), .pend_cnt(b_pcnt), .flush(b_flush)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model of the default instance: architectural contents and pending set.
    logic [31:0] mem_m [32];
    bit          pend_m [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = '0;
            pend_m[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] adr);
        if (adr == 0) return '0;
        if (a_en && a_wa == adr) return a_wd;
        return mem_m[adr];
    endfunction

    function automatic logic exp_busy(input logic [4:0] adr);
        if (adr == 0) return 1'b0;
        if (a_en && a_wa == adr) return 1'b0;
        return pend_m[adr];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(pend_m[i]);
        return c;
    endfunction

    // Called at posedge+1 with inputs already driven: check outputs, advance model, clock.
    task automatic tick_a();
        #2;
        check_eq("rs1",  a_rs1,   exp_rd(a_adr1));
        check_eq("rs2",  a_rs2,   exp_rd(a_adr2));
        check_eq("busy1", a_busy1, exp_busy(a_adr1));
        check_eq("busy2", a_busy2, exp_busy(a_adr2));
        check_eq("pend_cnt", a_pcnt, exp_cnt());
        if (a_en && a_wa != 0) mem_m[a_wa] = a_wd;
        if (a_flush) begin
            for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
        end else begin
            if (a_en) pend_m[a_wa] = 1'b0;
            if (a_iss && a_ia != 0) pend_m[a_ia] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_en = 1'b0; a_iss = 1'b0; a_flush = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset held for three cycles with a non-zero read address
        a_adr1 = 5;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rs1", a_rs1, 32'h0);
        check_eq("rst_busy1", a_busy1, 1'b0);
        check_eq("rst_pcnt", a_pcnt, 6'd0);
        a_adr1 = 0;
        #1;
        check_eq("rst_rs1_a0", a_rs1, 32'h0);
        check_eq("rst_busy1_a0", a_busy1, 1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write x5, then reset asynchronously mid-cycle
        a_en = 1'b1; a_wa = 5; a_wd = 32'hDEADBEEF; a_adr1 = 5;
        tick_a();
        idle_a();
        tick_a();
        check_eq("x5_written", a_rs1, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_rs1", a_rs1, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bypass on read, persistence after the edge, zero register ignores writes
        a_en = 1'b1; a_wa = 7; a_wd = 32'h12345678; a_adr1 = 7;
        #1;
        check_eq("bypass_rs1", a_rs1, 32'h12345678);
        tick_a();
        idle_a();
        tick_a();
        check_eq("x7_kept", a_rs1, 32'h12345678);
        a_en = 1'b1; a_wa = 0; a_wd = 32'hFFFFFFFF; a_adr2 = 0;
        tick_a();
        idle_a();
        tick_a();
        check_eq("x0_zero", a_rs2, 32'h0);

        // Issue x3, then writeback it three cycles later
        a_adr1 = 3; a_iss = 1'b1; a_ia = 3;
        tick_a();
        idle_a();
        check_eq("busy_x3", a_busy1, 1'b1);
        check_eq("pcnt_x3", a_pcnt, 6'd1);
        tick_a();
        tick_a();
        a_en = 1'b1; a_wa = 3; a_wd = 32'hA5;
        #1;
        check_eq("wb_busy_bypass", a_busy1, 1'b0);
        check_eq("wb_rs1_bypass", a_rs1, 32'hA5);
        tick_a();
        idle_a();
        check_eq("pcnt_after_wb", a_pcnt, 6'd0);

        // Issue and writeback to the same register in one cycle: issue wins
        a_iss = 1'b1; a_ia = 9;
        tick_a();
        a_en = 1'b1; a_wa = 9; a_wd = 32'h55;
        tick_a();
        idle_a();
        a_adr1 = 9;
        #1;
        check_eq("iss_wb_busy", a_busy1, 1'b1);
        check_eq("iss_wb_data", a_rs1, 32'h55);
        check_eq("iss_wb_pcnt", a_pcnt, 6'd1);
        tick_a();

        // Flush drops all pending bits and a simultaneous issue
        a_flush = 1'b1;
        tick_a();
        a_flush = 1'b0; a_adr1 = 4; a_adr2 = 2;
        for (int r = 1; r <= 3; r++) begin
            a_iss = 1'b1; a_ia = 5'(r);
            tick_a();
            check_eq("flush_ramp_pcnt", a_pcnt, 6'(r));
        end
        a_iss = 1'b1; a_ia = 4; a_flush = 1'b1;
        tick_a();
        idle_a();
        check_eq("flush_pcnt", a_pcnt, 6'd0);
        check_eq("flush_busy_x4", a_busy1, 1'b0);
        check_eq("flush_x2_busy", a_busy2, 1'b0);
        tick_a();

        // Randomized traffic, with read addresses often aimed at the write port
        for (int k = 0; k < 400; k++) begin
            a_en    = 1'($urandom_range(0, 1));
            a_wa    = 5'($urandom);
            a_wd    = $urandom;
            a_iss   = 1'($urandom_range(0, 1));
            a_ia    = ($urandom_range(0, 3) == 0) ? a_wa : 5'($urandom);
            a_flush = ($urandom_range(0, 24) == 0);
            a_adr1  = ($urandom_range(0, 3) == 0) ? a_wa : 5'($urandom);
            a_adr2  = ($urandom_range(0, 5) == 0) ? a_adr1 : 5'($urandom);
            tick_a();
        end
        idle_a();
        tick_a();

        // 16 x 64-bit instance without bypass
        b_iss = 1'b1; b_ia = 15; b_adr1 = 15; b_adr2 = 0;
        #2;
        check_eq("b_busy_pre", b_busy1, 1'b0);
        @(posedge clk); #1;
        b_iss = 1'b0;
        b_en = 1'b1; b_wa = 15; b_wd = 64'h0123456789ABCDEF;
        #2;
        check_eq("b_rs1_old", b_rs1, 64'h0);
        check_eq("b_busy_wb", b_busy1, 1'b1);
        check_eq("b_pcnt_1", b_pcnt, 5'd1);
        @(posedge clk); #1;
        b_en = 1'b0;
        #2;
        check_eq("b_rs1_new", b_rs1, 64'h0123456789ABCDEF);
        check_eq("b_busy_done", b_busy1, 1'b0);
        check_eq("b_pcnt_0", b_pcnt, 5'd0);
        check_eq("b_rs2_zero", b_rs2, 64'h0);
        b_en = 1'b1; b_wa = 0; b_wd = '1;
        @(posedge clk); #1;
        b_en = 1'b0;
        #2;
        check_eq("b_x0_zero", b_rs2, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-cycle OTTER register file, sized for the pipelined core.
- Provides two combinational read ports and one synchronous write port, with an optional write-to-read bypass and an optional hardwired zero register.
- Adds a per-register scoreboard of pending writebacks. The decode stage uses its busy flags and pending count to generate stalls.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; must be a power of two, at least 2
AW, $clog2(NREGS), register address width (derived, not overridden)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and issues
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports and clears busy

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
rf_adr1  input  AW  read port 1 address
rf_adr2  input  AW  read port 2 address
rf_rs1  output  XLEN  read port 1 data
rf_rs2  output  XLEN  read port 2 data
rf_en  input  1  writeback enable
rf_wa  input  AW  writeback address
rf_wd  input  XLEN  writeback data
iss_en  input  1  issue: mark destination rf_ia pending
rf_ia  input  AW  issue destination address
busy1  output  1  register at rf_adr1 has an unresolved pending write
busy2  output  1  register at rf_adr2 has an unresolved pending write
pend_cnt  output  AW+1  number of registers currently marked pending
flush  input  1  synchronous clear of all pending bits; register data untouched

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0: all registers = 0, all pending bits = 0, pend_cnt = 0. With constant-0 addresses, rf_rs1, rf_rs2, busy1 and busy2 all read 0.
- Reset asserted mid-operation discards any in-flight write and all pending bits immediately, without waiting for a clock edge.
- Reads are combinational, zero latency. rf_rsN = mem[rf_adrN], with two overrides, highest priority first:
  - ZERO_REG=1 and rf_adrN=0: data is 0.
  - BYPASS=1, rf_en=1, rf_wa=rf_adrN: data is rf_wd.
- Write: at the rising edge, if rf_en=1 then mem[rf_wa] <= rf_wd. The write is ignored when ZERO_REG=1 and rf_wa=0.
- Scoreboard update at each rising edge, per register r, in priority order:
  1. flush=1: all pending bits cleared. An issue in the same cycle is also dropped.
  2. iss_en=1 and rf_ia=r: pending[r] <= 1. Set wins over a simultaneous writeback to the same r, because the new producer supersedes the old one.
  3. rf_en=1 and rf_wa=r: pending[r] <= 0.
  4. Otherwise pending[r] holds.
- Issues to register 0 are ignored when ZERO_REG=1.
- Issue to an already-pending register: the bit stays 1 and pend_cnt does not change. The scoreboard tracks only the most recent producer.
- Writeback to a non-pending register is legal: data is written, the pending bit stays 0.
- busyN = pending[rf_adrN], forced to 0 in two cases:
  - ZERO_REG=1 and rf_adrN=0.
  - BYPASS=1, rf_en=1, rf_wa=rf_adrN (the data is resolved this cycle).
- busyN is combinational from the current pending state. An issue in cycle t is visible on busy from cycle t+1.
- pend_cnt is a registered population count of the pending bits. It is updated with the same edge semantics as the bits.
  - Range 0..NREGS, or 0..NREGS-1 when ZERO_REG=1. It never wraps.
- Identical addresses on both read ports are legal; both ports return identical data and busy.

Decomposition:
- Package rf_pkg holds:
  - XLEN_DEF = 32 and NREGS_DEF = 32.
  - Typedef rf_addr_t = logic [4:0] for default-config users.
  - Typedef rf_word_t = logic [31:0].
- Sub-module rf_scoreboard (NREGS, ZERO_REG) owns:
  - the pending-bit vector and the pend_cnt register;
  - the iss_en, rf_ia, rf_en, rf_wa and flush handling.
  - It outputs the pending vector. Busy masking and bypass stay in the top level.

Test Plan:
- Reset pulse low for 3 cycles with adr1=5 -> rf_rs1=0, busy1=0, pend_cnt=0. Write x5=0xDEADBEEF, then reset mid-cycle -> rf_rs1 returns to 0 immediately, with no clock edge.
- rf_en=1, rf_wa=7, rf_wd=0x12345678, rf_adr1=7, same cycle -> rf_rs1=0x12345678 combinationally (BYPASS=1). After the edge, with rf_en=0 -> still 0x12345678. Writing x0=0xFFFFFFFF -> rf_rs2 at adr 0 reads 0.
- Issue x3 at cycle 1, with adr1=3 -> busy1=1 from cycle 2 and pend_cnt=1. Writeback x3=0xA5 at cycle 4 -> busy1=0 in cycle 4 (bypass), rf_rs1=0xA5, pend_cnt=0 after the edge.
- Same cycle: iss_en on x9 and rf_en on x9 (old pending), rf_wd=0x55 -> after the edge, pending[9]=1, mem[9]=0x55, pend_cnt unchanged at 1.
- Issue x1, x2, x3 on consecutive cycles, then flush together with iss_en on x4 -> pend_cnt goes 1, 2, 3, then 0. busy for x4 = 0. Register data unchanged.
- Re-run with NREGS=16, XLEN=64, BYPASS=0 and write x15=0x0123456789ABCDEF -> same-cycle read returns the old value (0). Next cycle returns the new value. Busy stays 1 during the writeback cycle.
